// File: rtl/calendar_counter.sv
// Calendar-aware BCD date/time counter with leap years and validated parallel load.
// Optional day-of-week counter compiled in with `define CAL_DOW_EN.
module calendar_counter #(
   parameter int unsigned YEAR_DIGITS = 2,
   parameter logic [15:0] RST_YEAR    = 16'h2000
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     inc_i,
   input  logic                     load_i,
   input  logic [4*YEAR_DIGITS-1:0] year_load_i,
   input  logic [7:0]               month_load_i,
   input  logic [7:0]               day_load_i,
   input  logic [7:0]               hour_load_i,
   input  logic [7:0]               minute_load_i,
   input  logic [7:0]               second_load_i,
   output logic [4*YEAR_DIGITS-1:0] year_o,
   output logic [7:0]               month_o,
   output logic [7:0]               day_o,
   output logic [7:0]               hour_o,
   output logic [7:0]               minute_o,
   output logic [7:0]               second_o,
   output logic                     minute_tick_o,
   output logic                     hour_tick_o,
   output logic                     day_tick_o,
`ifdef CAL_DOW_EN
   output logic [2:0]               dow_o,
`endif
   output logic                     load_err_o
);

   localparam int unsigned YW = 4 * YEAR_DIGITS;

   function automatic logic [7:0] bcd_inc(input logic [7:0] p);
      if (p[3:0] == 4'd9) return {4'(p[7:4] + 4'd1), 4'h0};
      return {p[7:4], 4'(p[3:0] + 4'd1)};
   endfunction

   function automatic logic pair_ok(input logic [7:0] p);
      return (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9);
   endfunction

   // Tens parity decides which ones digits make the pair divisible by 4.
   function automatic logic is_mod4(input logic [7:0] p);
      if (p[4]) return (p[3:0] == 4'd2) || (p[3:0] == 4'd6);
      return (p[3:0] == 4'd0) || (p[3:0] == 4'd4) || (p[3:0] == 4'd8);
   endfunction

   function automatic logic is_leap(input logic [15:0] y);
      if (YEAR_DIGITS == 4 && y[7:0] == 8'h00) return is_mod4(y[15:8]);
      return is_mod4(y[7:0]);
   endfunction

   function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
      case (m)
         8'h02:                      return leap ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   logic [YW-1:0] year_q;
   logic [7:0]    month_q, day_q, hour_q, minute_q, second_q;
   logic          minute_tick_q, hour_tick_q, day_tick_q, load_err_q;

   logic [15:0]   year_pad, ld_pad;
   logic [7:0]    cur_len, ld_len, yr_lo_nx, yr_hi_nx;
   logic [YW-1:0] year_nx;
   logic          load_ok, inc_en, c_min, c_hour, c_day, c_month, c_year;

   always_comb begin
      year_pad = 16'(year_q);
      ld_pad   = 16'(year_load_i);
      cur_len  = month_len(month_q, is_leap(year_pad));
      ld_len   = month_len(month_load_i, is_leap(ld_pad));

      inc_en  = inc_i & ~load_i;
      c_min   = inc_en & (second_q == 8'h59);
      c_hour  = c_min & (minute_q == 8'h59);
      c_day   = c_hour & (hour_q == 8'h23);
      c_month = c_day & (day_q == cur_len);
      c_year  = c_month & (month_q == 8'h12);

      yr_lo_nx = (year_pad[7:0] == 8'h99) ? 8'h00 : bcd_inc(year_pad[7:0]);
      yr_hi_nx = year_pad[15:8];
      if (year_pad[7:0] == 8'h99) begin
         yr_hi_nx = (year_pad[15:8] == 8'h99) ? 8'h00 : bcd_inc(year_pad[15:8]);
      end
      year_nx = YW'({yr_hi_nx, yr_lo_nx});

      load_ok = pair_ok(ld_pad[15:8]) && pair_ok(ld_pad[7:0]) &&
                pair_ok(month_load_i) && pair_ok(day_load_i) && pair_ok(hour_load_i) &&
                pair_ok(minute_load_i) && pair_ok(second_load_i) &&
                (month_load_i >= 8'h01) && (month_load_i <= 8'h12) &&
                (day_load_i >= 8'h01) && (day_load_i <= ld_len) &&
                (hour_load_i <= 8'h23) && (minute_load_i <= 8'h59) &&
                (second_load_i <= 8'h59);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         year_q        <= RST_YEAR[YW-1:0];
         month_q       <= 8'h01;
         day_q         <= 8'h01;
         hour_q        <= 8'h00;
         minute_q      <= 8'h00;
         second_q      <= 8'h00;
         minute_tick_q <= 1'b0;
         hour_tick_q   <= 1'b0;
         day_tick_q    <= 1'b0;
         load_err_q    <= 1'b0;
      end else begin
         minute_tick_q <= c_min;
         hour_tick_q   <= c_hour;
         day_tick_q    <= c_day;
         load_err_q    <= load_i & ~load_ok;
         if (load_i) begin
            if (load_ok) begin
               year_q   <= year_load_i;
               month_q  <= month_load_i;
               day_q    <= day_load_i;
               hour_q   <= hour_load_i;
               minute_q <= minute_load_i;
               second_q <= second_load_i;
            end
         end else if (inc_i) begin
            second_q <= (second_q == 8'h59) ? 8'h00 : bcd_inc(second_q);
            if (c_min)   minute_q <= (minute_q == 8'h59) ? 8'h00 : bcd_inc(minute_q);
            if (c_hour)  hour_q   <= (hour_q == 8'h23) ? 8'h00 : bcd_inc(hour_q);
            if (c_day)   day_q    <= (day_q == cur_len) ? 8'h01 : bcd_inc(day_q);
            if (c_month) month_q  <= (month_q == 8'h12) ? 8'h01 : bcd_inc(month_q);
            if (c_year)  year_q   <= year_nx;
         end
      end
   end

   assign year_o        = year_q;
   assign month_o       = month_q;
   assign day_o         = day_q;
   assign hour_o        = hour_q;
   assign minute_o      = minute_q;
   assign second_o      = second_q;
   assign minute_tick_o = minute_tick_q;
   assign hour_tick_o   = hour_tick_q;
   assign day_tick_o    = day_tick_q;
   assign load_err_o    = load_err_q;

`ifdef CAL_DOW_EN
   // Sakamoto's method reduced mod 7: with y = 100*yh + yl the year part is
   // 5*yh + yh/4 + yl + yl/4; one term is accumulated per cycle.
   typedef enum logic [0:0] {StIdle, StCalc} dow_state_e;

   function automatic logic [7:0] bcd_dec(input logic [7:0] p);
      if (p[3:0] == 4'd0) return {4'(p[7:4] - 4'd1), 4'h9};
      return {p[7:4], 4'(p[3:0] - 4'd1)};
   endfunction

   function automatic logic [6:0] bcd2bin(input logic [7:0] p);
      return 7'(p[7:4]) * 7'd10 + 7'(p[3:0]);
   endfunction

   function automatic logic [6:0] month_off(input logic [7:0] m);
      case (m)
         8'h02, 8'h06:        return 7'd3;
         8'h03, 8'h11:        return 7'd2;
         8'h04, 8'h07:        return 7'd5;
         8'h08:               return 7'd1;
         8'h09, 8'h12:        return 7'd4;
         8'h10:               return 7'd6;
         default:             return 7'd0;
      endcase
   endfunction

   dow_state_e dow_state_q;
   logic [2:0] dow_q, acc_q, acc_d, step_q;
   logic [7:0] yh_q, yl_q, cm_q, cd_q, lo_dec, hi_dec;
   logic [6:0] yh_b, yl_b, term;
   logic [15:0] calc_year;

   always_comb begin
      // Two-digit years live in 2000-2099; Jan/Feb count toward the previous year.
      // 0000 wraps to 9999, which is congruent mod 400 and keeps the weekday right.
      calc_year = (YEAR_DIGITS == 4) ? ld_pad : {8'h20, ld_pad[7:0]};
      lo_dec    = (calc_year[7:0] == 8'h00) ? 8'h99 : bcd_dec(calc_year[7:0]);
      hi_dec    = calc_year[15:8];
      if (calc_year[7:0] == 8'h00) begin
         hi_dec = (calc_year[15:8] == 8'h00) ? 8'h99 : bcd_dec(calc_year[15:8]);
      end
      if (month_load_i < 8'h03) calc_year = {hi_dec, lo_dec};

      yh_b = bcd2bin(yh_q);
      yl_b = bcd2bin(yl_q);
      case (step_q)
         3'd0:    term = 7'((yh_b % 7'd7) * 7'd5);
         3'd1:    term = yh_b >> 2;
         3'd2:    term = yl_b;
         3'd3:    term = yl_b >> 2;
         3'd4:    term = month_off(cm_q);
         3'd5:    term = bcd2bin(cd_q);
         default: term = 7'd6;  // shift Sunday=0 to Monday=0
      endcase
      acc_d = 3'((8'(acc_q) + 8'(term) + 8'(c_day)) % 8'd7);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dow_state_q <= StIdle;
         dow_q       <= 3'd5;
         acc_q       <= 3'd0;
         step_q      <= 3'd0;
         yh_q        <= 8'h00;
         yl_q        <= 8'h00;
         cm_q        <= 8'h00;
         cd_q        <= 8'h00;
      end else if (load_i && load_ok) begin
         dow_state_q <= StCalc;
         acc_q       <= 3'd0;
         step_q      <= 3'd0;
         yh_q        <= calc_year[15:8];
         yl_q        <= calc_year[7:0];
         cm_q        <= month_load_i;
         cd_q        <= day_load_i;
      end else begin
         case (dow_state_q)
            StIdle: if (c_day) dow_q <= (dow_q == 3'd6) ? 3'd0 : 3'(dow_q + 3'd1);
            StCalc: begin
               acc_q  <= acc_d;
               step_q <= 3'(step_q + 3'd1);
               if (step_q == 3'd6) begin
                  dow_q       <= acc_d;
                  dow_state_q <= StIdle;
               end
            end
            default: dow_state_q <= StIdle;
         endcase
      end
   end

   assign dow_o = dow_q;
`endif

endmodule

// File: tb/tb_calendar_counter.sv
// Table-driven bench for calendar_counter: a 2-digit and a 4-digit instance,
// plus hand sequences for reset, back-to-back increments and day of week.
module tb_calendar_counter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inc [2];
   logic        load [2];
   logic [7:0]  yl2;
   logic [15:0] yl4;
   logic [7:0]  mo_ld, d_ld, h_ld, mi_ld, s_ld;
   logic [7:0]  yr2;
   logic [15:0] yr4;
   logic [7:0]  mo [2], dd [2], hh [2], mi [2], ss [2];
   logic        mt [2], ht [2], dt [2], le [2];
`ifdef CAL_DOW_EN
   logic [2:0]  dow [2];
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   calendar_counter #(.YEAR_DIGITS(2), .RST_YEAR(16'h2000)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .inc_i(inc[0]), .load_i(load[0]),
      .year_load_i(yl2), .month_load_i(mo_ld), .day_load_i(d_ld), .hour_load_i(h_ld),
      .minute_load_i(mi_ld), .second_load_i(s_ld),
      .year_o(yr2), .month_o(mo[0]), .day_o(dd[0]), .hour_o(hh[0]), .minute_o(mi[0]),
      .second_o(ss[0]), .minute_tick_o(mt[0]), .hour_tick_o(ht[0]), .day_tick_o(dt[0]),
`ifdef CAL_DOW_EN
      .dow_o(dow[0]),
`endif
      .load_err_o(le[0])
   );

   calendar_counter #(.YEAR_DIGITS(4), .RST_YEAR(16'h2000)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .inc_i(inc[1]), .load_i(load[1]),
      .year_load_i(yl4), .month_load_i(mo_ld), .day_load_i(d_ld), .hour_load_i(h_ld),
      .minute_load_i(mi_ld), .second_load_i(s_ld),
      .year_o(yr4), .month_o(mo[1]), .day_o(dd[1]), .hour_o(hh[1]), .minute_o(mi[1]),
      .second_o(ss[1]), .minute_tick_o(mt[1]), .hour_tick_o(ht[1]), .day_tick_o(dt[1]),
`ifdef CAL_DOW_EN
      .dow_o(dow[1]),
`endif
      .load_err_o(le[1])
   );

   typedef struct {
      bit          sel;     // 0: 2-digit instance, 1: 4-digit instance
      bit          ld;
      bit          inc;
      logic [15:0] y;
      logic [39:0] mdhms;
      logic [15:0] ey;
      logic [39:0] emdhms;
      logic [3:0]  fl;      // {minute_tick, hour_tick, day_tick, load_err}
      string       nm;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit sel, input bit ld, input bit inc_v,
                               input logic [15:0] y, input logic [39:0] mdhms,
                               input logic [15:0] ey, input logic [39:0] emdhms,
                               input logic [3:0] fl, input string nm);
      vec_t v;
      v.sel = sel; v.ld = ld; v.inc = inc_v; v.y = y; v.mdhms = mdhms;
      v.ey = ey; v.emdhms = emdhms; v.fl = fl; v.nm = nm;
      vecs.push_back(v);
   endfunction

   function automatic logic [55:0] state_of(input bit i);
      if (i == 1'b0) return {8'h00, yr2, mo[0], dd[0], hh[0], mi[0], ss[0]};
      return {yr4, mo[1], dd[1], hh[1], mi[1], ss[1]};
   endfunction

   function automatic logic [3:0] flags_of(input bit i);
      return {mt[i], ht[i], dt[i], le[i]};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      inc[v.sel]  = v.inc;
      load[v.sel] = v.ld;
      if (v.sel) yl4 = v.y;
      else yl2 = v.y[7:0];
      {mo_ld, d_ld, h_ld, mi_ld, s_ld} = v.mdhms;
      @(negedge clk);
      inc[v.sel]  = 1'b0;
      load[v.sel] = 1'b0;
      check({v.nm, " state"}, 64'(state_of(v.sel)), 64'({v.ey, v.emdhms}));
      check({v.nm, " flags"}, 64'(flags_of(v.sel)), 64'(v.fl));
   endtask

   task automatic load2(input logic [7:0] y, input logic [39:0] mdhms);
      vec_t v;
      v.sel = 1'b0; v.ld = 1'b1; v.inc = 1'b0; v.y = {8'h00, y}; v.mdhms = mdhms;
      v.ey = {8'h00, y}; v.emdhms = mdhms; v.fl = 4'b0000; v.nm = "load2";
      apply(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0;
      inc[0] = 1'b0; inc[1] = 1'b0; load[0] = 1'b0; load[1] = 1'b0;
      yl2 = '0; yl4 = '0; {mo_ld, d_ld, h_ld, mi_ld, s_ld} = '0;

      // 2-digit instance
      add(0,1,0,16'h99,40'h12_31_23_59_59,16'h99,40'h12_31_23_59_59,4'b0000,"load_9912");
      add(0,0,1,16'h00,40'h0,16'h00,40'h01_01_00_00_00,4'b1110,"wrap_99");
      add(0,1,0,16'h24,40'h02_28_23_59_59,16'h24,40'h02_28_23_59_59,4'b0000,"load_2402");
      add(0,0,1,16'h00,40'h0,16'h24,40'h02_29_00_00_00,4'b1110,"leap_24");
      add(0,1,0,16'h23,40'h02_28_23_59_59,16'h23,40'h02_28_23_59_59,4'b0000,"load_2302");
      add(0,0,1,16'h00,40'h0,16'h23,40'h03_01_00_00_00,4'b1110,"noleap_23");
      add(0,1,0,16'h24,40'h04_31_12_34_56,16'h23,40'h03_01_00_00_00,4'b0001,"bad_apr31");
      add(0,1,0,16'h24,40'h13_01_00_00_00,16'h23,40'h03_01_00_00_00,4'b0001,"bad_mon13");
      add(0,1,0,16'h24,40'h01_01_00_00_5A,16'h23,40'h03_01_00_00_00,4'b0001,"bad_sec5a");
      add(0,1,0,16'h24,40'h01_01_24_00_00,16'h23,40'h03_01_00_00_00,4'b0001,"bad_hour24");
      add(0,1,0,16'h24,40'h01_00_00_00_00,16'h23,40'h03_01_00_00_00,4'b0001,"bad_day00");
      add(0,1,0,16'h2A,40'h01_01_00_00_00,16'h23,40'h03_01_00_00_00,4'b0001,"bad_year");
      add(0,1,0,16'h24,40'h01_01_00_3A_00,16'h23,40'h03_01_00_00_00,4'b0001,"bad_min3a");
      add(0,1,0,16'h24,40'h02_29_10_20_30,16'h24,40'h02_29_10_20_30,4'b0000,"load_feb29");
      add(0,1,1,16'h24,40'h06_30_12_00_00,16'h24,40'h06_30_12_00_00,4'b0000,"ld_inc_prio");
      add(0,0,1,16'h00,40'h0,16'h24,40'h06_30_12_00_01,4'b0000,"inc_sec");
      add(0,1,1,16'h24,40'h13_01_00_00_00,16'h24,40'h06_30_12_00_01,4'b0001,"bad_ld_inc");
      add(0,1,0,16'h24,40'h06_30_23_59_59,16'h24,40'h06_30_23_59_59,4'b0000,"load_jun30");
      add(0,0,1,16'h00,40'h0,16'h24,40'h07_01_00_00_00,4'b1110,"jun_end");
      add(0,1,0,16'h24,40'h01_31_10_59_59,16'h24,40'h01_31_10_59_59,4'b0000,"load_1059");
      add(0,0,1,16'h00,40'h0,16'h24,40'h01_31_11_00_00,4'b1100,"hour_tick");
      add(0,1,0,16'h24,40'h01_31_10_00_59,16'h24,40'h01_31_10_00_59,4'b0000,"load_0059");
      add(0,0,1,16'h00,40'h0,16'h24,40'h01_31_10_01_00,4'b1000,"min_tick");
      add(0,1,0,16'h98,40'h12_31_23_59_59,16'h98,40'h12_31_23_59_59,4'b0000,"load_9812");
      add(0,0,1,16'h00,40'h0,16'h99,40'h01_01_00_00_00,4'b1110,"year_inc");
      add(0,1,0,16'h00,40'h02_29_00_00_00,16'h00,40'h02_29_00_00_00,4'b0000,"leap_00");
      // 4-digit instance
      add(1,1,0,16'h2100,40'h02_28_23_59_59,16'h2100,40'h02_28_23_59_59,4'b0000,"load_2100");
      add(1,0,1,16'h0,40'h0,16'h2100,40'h03_01_00_00_00,4'b1110,"c2100_noleap");
      add(1,1,0,16'h2000,40'h02_28_23_59_59,16'h2000,40'h02_28_23_59_59,4'b0000,"load_2000");
      add(1,0,1,16'h0,40'h0,16'h2000,40'h02_29_00_00_00,4'b1110,"c2000_leap");
      add(1,1,0,16'h2100,40'h02_29_00_00_00,16'h2000,40'h02_29_00_00_00,4'b0001,"bad_2100_229");
      add(1,1,0,16'h9999,40'h12_31_23_59_59,16'h9999,40'h12_31_23_59_59,4'b0000,"load_9999");
      add(1,0,1,16'h0,40'h0,16'h0000,40'h01_01_00_00_00,4'b1110,"wrap_9999");
      add(1,1,0,16'h2099,40'h12_31_23_59_59,16'h2099,40'h12_31_23_59_59,4'b0000,"load_2099");
      add(1,0,1,16'h0,40'h0,16'h2100,40'h01_01_00_00_00,4'b1110,"cent_carry");
      add(1,1,0,16'h20A4,40'h01_01_00_00_00,16'h2100,40'h01_01_00_00_00,4'b0001,"bad_yr_nib");
      add(1,1,0,16'h1996,40'h02_29_08_00_00,16'h1996,40'h02_29_08_00_00,4'b0000,"load_1996");

      // Reset state
      repeat (2) @(negedge clk);
      check("rst2 state", 64'(state_of(0)), 64'({16'h0000, 40'h01_01_00_00_00}));
      check("rst4 state", 64'(state_of(1)), 64'({16'h2000, 40'h01_01_00_00_00}));
      check("rst flags", 64'({flags_of(0), flags_of(1)}), 64'h0);
`ifdef CAL_DOW_EN
      check("rst dow", 64'({dow[0], dow[1]}), 64'({3'd5, 3'd5}));
`endif
      rst_n = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // 60 back-to-back increments from :00 give exactly one minute tick
      load2(8'h24, 40'h01_01_10_00_00);
      n = 0;
      @(negedge clk);
      inc[0] = 1'b1;
      repeat (60) begin
         @(negedge clk);
         n += int'(mt[0]);
      end
      inc[0] = 1'b0;
      check("b2b min ticks", 64'(n), 64'd1);
      check("b2b state", 64'(state_of(0)), 64'({16'h0024, 40'h01_01_10_01_00}));
      @(negedge clk);
      check("b2b tick low", 64'(mt[0]), 64'd0);

      // Asynchronous reset mid-operation
      load2(8'h24, 40'h05_05_05_05_05);
      @(negedge clk);
      inc[0] = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async rst2", 64'(state_of(0)), 64'({16'h0000, 40'h01_01_00_00_00}));
      check("async rst4", 64'(state_of(1)), 64'({16'h2000, 40'h01_01_00_00_00}));
      check("async flags", 64'({flags_of(0), flags_of(1)}), 64'h0);
      @(negedge clk);
      inc[0] = 1'b0;
      rst_n = 1'b1;

`ifdef CAL_DOW_EN
      // 2024-03-15 is a Friday
      @(negedge clk);
      load[0] = 1'b1; load[1] = 1'b1;
      yl2 = 8'h24; yl4 = 16'h2024; {mo_ld, d_ld, h_ld, mi_ld, s_ld} = 40'h03_15_00_00_00;
      @(negedge clk);
      load[0] = 1'b0; load[1] = 1'b0;
      check("dow held", 64'(dow[0]), 64'd5);
      n = 0;
      while (dow[0] !== 3'd4 && n < 16) begin
         @(negedge clk);
         n++;
      end
      check("dow2 0315", 64'(dow[0]), 64'd4);
      check("dow4 0315", 64'(dow[1]), 64'd4);
      // Sunday 23:59:59 rolls to Monday
      load2(8'h24, 40'h03_17_23_59_59);
      repeat (16) @(negedge clk);
      check("dow sunday", 64'(dow[0]), 64'd6);
      inc[0] = 1'b1;
      @(negedge clk);
      inc[0] = 1'b0;
      check("dow monday", 64'(dow[0]), 64'd0);
      check("dow day tick", 64'(dt[0]), 64'd1);
      // Rollover while the calculation is still running
      load2(8'h24, 40'h03_17_23_59_59);
      inc[0] = 1'b1;
      @(negedge clk);
      inc[0] = 1'b0;
      repeat (16) @(negedge clk);
      check("dow mid-calc", 64'(dow[0]), 64'd0);
      check("mid-calc date", 64'(state_of(0)), 64'({16'h0024, 40'h03_18_00_00_00}));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
